// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared PWM timebase constants and the duty-slew helpers used by the ramp controller.
package pwm_ramp_ctrl_pkg;

  localparam int SYS_CLK_HZ  = 50_000_000;
  localparam int PWM_TICK_HZ = 200_000;
  localparam int PWM_PERIOD  = 10000;
  localparam int DEF_CLK_DIV = SYS_CLK_HZ / PWM_TICK_HZ;

  typedef enum logic [1:0] {
    DIR_HOLD,
    DIR_JUMP,
    DIR_UP,
    DIR_DOWN
  } ramp_dir_e;

  function automatic ramp_dir_e ramp_dir(input logic [15:0] duty,
                                         input logic [15:0] tgt,
                                         input logic        jump);
    if (duty == tgt) return DIR_HOLD;
    if (jump)        return DIR_JUMP;
    return (duty < tgt) ? DIR_UP : DIR_DOWN;
  endfunction

  // Saturating narrow: 17-bit working values never wrap before clamping.
  function automatic logic [15:0] sat16(input logic [16:0] v, input logic [16:0] lim);
    return (v > lim) ? lim[15:0] : v[15:0];
  endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// PWM frame timebase: prescaler to the PWM tick, then a tick counter that flags frame ends.
module pwm_frame_timer #(
  parameter int CLK_DIV = 250,
  parameter int PERIOD  = 10000
) (
  input  logic clock,
  input  logic reset,
  output logic frame_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(PERIOD - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          frame_q, frame_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    tcnt_d  = tcnt_q;
    if (tick) tcnt_d = (tcnt_q == TICK_LAST) ? '0 : tcnt_q + 1'b1;
    frame_d = tick && (tcnt_q == TICK_LAST);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      tcnt_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      frame_q <= frame_d;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Slew-limited duty ramp feeding the PWM compare pair; compare values move only at frame ends.
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int PERIOD  = PWM_PERIOD,
  parameter int PHASE   = 0,
  parameter int STEP_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [15:0]       target,
  input  logic [STEP_W-1:0] step,
  output logic [15:0]       cr1,
  output logic [15:0]       cr2,
  output logic [15:0]       duty,
  output logic              busy,
  output logic              done,
  output logic              frame
);

  localparam logic [16:0] PERIOD_W = 17'(PERIOD);
  localparam logic [16:0] PHASE_W  = 17'(PHASE);

  logic        frame_q;
  logic [15:0] target_q, target_d;
  logic [15:0] duty_q, duty_d;
  logic [15:0] cr2_q, cr2_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [16:0] step_w, sum_w, gap_w;

  pwm_frame_timer #(
    .CLK_DIV(CLK_DIV),
    .PERIOD (PERIOD)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .frame_o(frame_q)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    target_d = target_q;
    duty_d   = duty_q;
    cr2_d    = cr2_q;
    done_d   = 1'b0;
    busy_d   = (duty_q != target_q);
    step_w   = 17'(step);
    sum_w    = {1'b0, duty_q} + step_w;
    gap_w    = {1'b0, duty_q - target_q};

    if (load) target_d = sat16({1'b0, target}, PERIOD_W);

    // Update reads the pre-edge target_q, so a load in the frame cycle waits a frame.
    if (frame_q) begin
      case (ramp_dir(duty_q, target_q, step == '0))
        DIR_JUMP: duty_d = target_q;
        DIR_UP:   duty_d = sat16(sum_w, {1'b0, target_q});
        DIR_DOWN: duty_d = (gap_w <= step_w) ? target_q : duty_q - step_w[15:0];
        default:  duty_d = duty_q;
      endcase
      cr2_d  = sat16(PHASE_W + {1'b0, duty_d}, PERIOD_W);
      done_d = (duty_q != target_q) && (duty_d == target_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      target_q <= '0;
      duty_q   <= '0;
      cr2_q    <= PHASE_W[15:0];
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      duty_q   <= duty_d;
      cr2_q    <= cr2_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cr1   = PHASE_W[15:0];
  assign cr2   = cr2_q;
  assign duty  = duty_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with a shortened frame (CLK_DIV=2, PERIOD=20, PHASE=0).
module tb_pwm_ramp_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] target = '0;
  logic [7:0]  step = '0;
  logic [15:0] cr1, cr2, duty;
  logic        busy, done, frame;

  int n_cmp  = 0;
  int n_fail = 0;

  pwm_ramp_ctrl #(
    .CLK_DIV(2),
    .PERIOD (20),
    .PHASE  (0),
    .STEP_W (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .target(target),
    .step  (step),
    .cr1   (cr1),
    .cr2   (cr2),
    .duty  (duty),
    .busy  (busy),
    .done  (done),
    .frame (frame)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        do_load;
    logic [15:0] tgt;
    logic [7:0]  stp;
    logic [15:0] exp_duty;
    logic [15:0] exp_cr2;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Returns in the frame cycle (at a falling edge with frame high).
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (frame) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL frame_timeout: no frame within 200 cycles");
    end
  endtask

  task automatic pulse_load(input logic [15:0] t, input logic [7:0] s);
    repeat (3) @(negedge clock);
    target = t;
    step   = s;
    load   = 1'b1;
    @(negedge clock);
    load   = 1'b0;
  endtask

  task automatic count_to_frame(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      n++;
      if (frame) break;
    end
  endtask

  initial begin
    int n;
    int bad;
    int frames_seen;

    vecs[0] = '{1'b1, 16'd10, 8'd3, 16'd3,  16'd3,  1'b1, 1'b0};
    vecs[1] = '{1'b0, 16'd10, 8'd3, 16'd6,  16'd6,  1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'd10, 8'd3, 16'd9,  16'd9,  1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'd10, 8'd3, 16'd10, 16'd10, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'd25, 8'd0, 16'd20, 16'd20, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 16'd2,  8'd7, 16'd13, 16'd13, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 16'd2,  8'd7, 16'd6,  16'd6,  1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'd2,  8'd7, 16'd2,  16'd2,  1'b0, 1'b1};
    vecs[8] = '{1'b1, 16'd20, 8'd8, 16'd10, 16'd10, 1'b1, 1'b0};

    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Get a nonzero duty, then reset asynchronously mid-ramp.
    pulse_load(16'd10, 8'd5);
    wait_frame();
    @(posedge clock);
    #1;
    check("pre_reset_duty", duty, 5);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rst_duty", duty, 0);
    check("rst_cr1", cr1, 0);
    check("rst_cr2", cr2, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame", frame, 0);

    @(negedge clock);
    reset = 1'b0;
    count_to_frame(n);
    check("first_frame_clock", n, 40);
    count_to_frame(n);
    check("frame_spacing", n, 40);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_load) pulse_load(vecs[i].tgt, vecs[i].stp);
      else step = vecs[i].stp;
      wait_frame();
      @(posedge clock);
      #1;
      check($sformatf("v%0d_duty", i), duty, vecs[i].exp_duty);
      check($sformatf("v%0d_cr2", i), cr2, vecs[i].exp_cr2);
      check($sformatf("v%0d_cr1", i), cr1, 0);
      check($sformatf("v%0d_done", i), done, vecs[i].exp_done);
      @(posedge clock);
      #1;
      check($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("v%0d_done_width", i), done, 0);
    end

    // Load coinciding with frame: this update still heads for 20, the next for 5.
    wait_frame();
    target = 16'd5;
    step   = 8'd8;
    load   = 1'b1;
    @(posedge clock);
    #1;
    load = 1'b0;
    check("sim_duty", duty, 18);
    check("sim_cr2", cr2, 18);
    check("sim_done", done, 0);
    wait_frame();
    @(posedge clock);
    #1;
    check("sim_next_duty", duty, 10);
    check("sim_next_done", done, 0);
    wait_frame();
    @(posedge clock);
    #1;
    check("sim_final_duty", duty, 5);
    check("sim_final_done", done, 1);
    @(posedge clock);
    #1;
    check("sim_final_busy", busy, 0);

    // Reloading the same target while idle must be silent across a frame.
    pulse_load(16'd5, 8'd8);
    bad = 0;
    frames_seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (frame) frames_seen++;
      if (busy || done || cr2 != 16'd5 || cr1 != 16'd0 || duty != 16'd5) bad++;
    end
    check("idle_frames_seen", frames_seen, 1);
    check("idle_activity", bad, 0);
    check("idle_cr2", cr2, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
